// File: rtl/data_unpack_pkg.sv
// Shared definitions for the byte-to-lane unpacker and its transmit-side counterpart.
package data_unpack_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DROP    = 1'b1
  } state_t;

  // Bytes per output word; also used by the transmit-side concat block.
  function automatic int unsigned calc_nb(input int unsigned bw,
                                          input int unsigned n_prl,
                                          input int unsigned bw_in);
    return (bw * n_prl) / bw_in;
  endfunction

endpackage

// File: rtl/data_unpack_byte_shift_acc.sv
// Shift accumulator: holds the first NB-1 bytes of a word, the completing byte is
// merged combinationally so the word can be registered on the byte that closes it.
module data_unpack_byte_shift_acc #(
  parameter int unsigned BW_IN = 8,
  parameter int unsigned NB    = 9
) (
  input  logic                  clk,
  input  logic                  srest_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [BW_IN-1:0]      din_i,
  output logic [BW_IN*NB-1:0]   word_c_o
);

  localparam int unsigned W  = BW_IN * NB;
  localparam int unsigned AW = W - BW_IN;

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;

  // New bytes enter at the top so the oldest byte ends up in the low slot.
  assign acc_d    = AW'({din_i, acc_q} >> BW_IN);
  assign word_c_o = {din_i, acc_q};

  always_ff @(posedge clk) begin
    if (srest_i || clr_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/data_unpack.sv
// Reassembles a byte stream into N_PRL lanes of BW bits, with frame-length checking
// and a single-entry output register with backpressure.
module data_unpack
  import data_unpack_pkg::*;
#(
  parameter int unsigned BW    = 18,
  parameter int unsigned N_PRL = 4,
  parameter int unsigned BW_IN = 8
) (
  input  logic                        clk,
  input  logic                        srest,
  input  logic [BW_IN-1:0]            s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_last,
  output logic [N_PRL-1:0][BW-1:0]    m_x,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        frame_err
);

  localparam int unsigned W  = BW * N_PRL;
  localparam int unsigned NB = calc_nb(BW, N_PRL, BW_IN);
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  if (((W % BW_IN) != 0) || (NB < 2)) begin : g_bad_cfg
    $error("data_unpack: BW*N_PRL must be a multiple of BW_IN spanning at least two bytes");
  end

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_PRL-1:0][BW-1:0]   mx_q, mx_d;
  logic                       mvalid_q, mvalid_d;
  logic                       mlast_q, mlast_d;
  logic                       ferr_q, ferr_d;
  logic                       acc_load, acc_clr;
  logic                       accept;
  logic [W-1:0]               word_c;

  data_unpack_byte_shift_acc #(
    .BW_IN (BW_IN),
    .NB    (NB)
  ) u_acc (
    .clk      (clk),
    .srest_i  (srest),
    .clr_i    (acc_clr),
    .load_i   (acc_load),
    .din_i    (s_data),
    .word_c_o (word_c)
  );

  // Only the completing byte can stall, and only when the held word is not leaving.
  assign s_ready = !srest &&
                   !((state_q == COLLECT) && (cnt_q == CNT_LAST) && mvalid_q && !m_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mx_d     = mx_q;
    mvalid_d = mvalid_q && !m_ready;
    mlast_d  = mlast_q;
    ferr_d   = 1'b0;
    acc_load = 1'b0;
    acc_clr  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            mx_d     = word_c;
            mvalid_d = 1'b1;
            mlast_d  = s_last;
            cnt_d    = '0;
          end else if (s_last) begin
            ferr_d  = 1'b1;
            cnt_d   = '0;
            acc_clr = 1'b1;
          end else begin
            cnt_d    = cnt_q + CW'(1);
            acc_load = 1'b1;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d = COLLECT;
          cnt_d   = '0;
          acc_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srest) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      mx_q     <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mx_q     <= mx_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      ferr_q   <= ferr_d;
    end
  end

  assign m_x       = mx_q;
  assign m_valid   = mvalid_q;
  assign m_last    = mlast_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: directed corner cases, then random frames against a
// frame-level reference built by concatenating bytes into words.
module tb_data_unpack;

  localparam int unsigned BW    = 18;
  localparam int unsigned N_PRL = 4;
  localparam int unsigned BW_IN = 8;
  localparam int unsigned W     = BW * N_PRL;
  localparam int unsigned NB    = W / BW_IN;

  logic                       clk = 1'b0;
  logic                       srest;
  logic [BW_IN-1:0]           s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic                       s_last;
  logic [N_PRL-1:0][BW-1:0]   m_x;
  logic                       m_valid;
  logic                       m_ready;
  logic                       m_last;
  logic                       frame_err;

  data_unpack #(.BW(BW), .N_PRL(N_PRL), .BW_IN(BW_IN)) dut (
    .clk       (clk),
    .srest     (srest),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .m_x       (m_x),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [BW_IN-1:0] d; logic l; } byte_t;
  typedef struct packed { logic [W-1:0] x; logic l; } word_t;

  int n_cmp = 0;
  int n_err = 0;

  byte_t            byte_q[$];
  word_t            exp_q[$];
  word_t            w;
  logic [W-1:0]     flat;
  logic [W-1:0]     exp_w;
  logic [BW_IN-1:0] bv;
  int               len, k, cyc, exp_ferr, got_ferr, got_words, words_planned;
  logic             took;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic send_byte(input logic [BW_IN-1:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) chk("send_timeout", 128'(0), 128'(1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    srest = 1'b1; s_valid = 1'b1; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_last", 128'(m_last), 128'(0));
    chk("rst_m_x", 128'(m_x), 128'(0));
    chk("rst_frame_err", 128'(frame_err), 128'(0));
    chk("rst_s_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    srest = 1'b0; s_valid = 1'b0;
    @(negedge clk);

    // Reference word from bytes 0x01..0x09
    m_ready = 1'b1;
    for (int i = 1; i <= 9; i++) send_byte(8'(i), i == 9);
    chk("ex1_m_valid", 128'(m_valid), 128'(1));
    chk("ex1_m_x", 128'(m_x), 128'({18'h02420, 18'h07060, 18'h14100, 18'h30201}));
    chk("ex1_m_last", 128'(m_last), 128'(1));
    @(negedge clk);
    chk("ex1_consumed", 128'(m_valid), 128'(0));

    // Backpressure on the completing byte, then no-bubble reload
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'hFF, 1'b0);
    chk("bp_word1_valid", 128'(m_valid), 128'(1));
    chk("bp_word1_x", 128'(m_x), 128'({W{1'b1}}));
    for (int i = 0; i < 8; i++) send_byte(8'hFF, 1'b0);
    chk("bp_mid_still_valid", 128'(m_valid), 128'(1));
    s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b0;
    #1;
    chk("bp_blocked0", 128'(s_ready), 128'(0));
    repeat (2) @(negedge clk);
    #1;
    chk("bp_blocked2", 128'(s_ready), 128'(0));
    chk("bp_held_valid", 128'(m_valid), 128'(1));
    m_ready = 1'b1;
    #1;
    chk("bp_released", 128'(s_ready), 128'(1));
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp_no_bubble", 128'(m_valid), 128'(1));
    chk("bp_word2_x", 128'(m_x), 128'({W{1'b1}}));
    @(negedge clk);
    chk("bp_word2_gone", 128'(m_valid), 128'(0));

    // Short frame: six bytes
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h30 + i), i == 6);
    chk("short_ferr", 128'(frame_err), 128'(1));
    chk("short_no_word", 128'(m_valid), 128'(0));
    @(negedge clk);
    chk("short_ferr_pulse", 128'(frame_err), 128'(0));
    chk("short_still_none", 128'(m_valid), 128'(0));
    for (int i = 0; i < 9; i++) begin
      exp_w[BW_IN*i +: BW_IN] = 8'(8'h40 + i);
      send_byte(8'(8'h40 + i), i == 8);
    end
    chk("short_next_valid", 128'(m_valid), 128'(1));
    chk("short_next_x", 128'(m_x), 128'(exp_w));
    chk("short_next_last", 128'(m_last), 128'(1));
    @(negedge clk);

    // Reset with a word pending and a partial word collected
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'h77, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0);
    srest = 1'b1;
    #1;
    chk("mrst_s_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    chk("mrst_m_valid", 128'(m_valid), 128'(0));
    chk("mrst_m_x", 128'(m_x), 128'(0));
    chk("mrst_m_last", 128'(m_last), 128'(0));
    chk("mrst_frame_err", 128'(frame_err), 128'(0));
    srest = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_w[BW_IN*i +: BW_IN] = 8'(8'h10 + i);
      send_byte(8'(8'h10 + i), i == 8);
    end
    chk("mrst_next_valid", 128'(m_valid), 128'(1));
    chk("mrst_next_x", 128'(m_x), 128'(exp_w));
    chk("mrst_next_last", 128'(m_last), 128'(1));
    @(negedge clk);

    // Random frames: expected words come from concatenating each frame's bytes
    words_planned = 0; exp_ferr = 0;
    while (words_planned < 1000) begin
      len = $urandom_range(1, 3 * NB);
      k = 0; flat = '0;
      for (int i = 0; i < len; i++) begin
        bv = BW_IN'($urandom);
        byte_q.push_back('{bv, (i == len - 1)});
        flat[BW_IN*k +: BW_IN] = bv;
        k++;
        if (k == NB) begin
          exp_q.push_back('{flat, (i == len - 1)});
          words_planned++;
          k = 0; flat = '0;
        end
      end
      if (k != 0) exp_ferr++;
    end

    cyc = 0; got_ferr = 0; got_words = 0; took = 1'b0;
    while ((byte_q.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (took) s_valid = 1'b0;
      if (!s_valid && byte_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        s_valid = 1'b1; s_data = byte_q[0].d; s_last = byte_q[0].l;
      end
      m_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (frame_err) got_ferr++;
      if (m_valid && m_ready) begin
        got_words++;
        if (exp_q.size() == 0) begin
          chk("rnd_extra_word", 128'(1), 128'(0));
        end else begin
          w = exp_q.pop_front();
          chk("rnd_m_x", 128'(m_x), 128'(w.x));
          chk("rnd_m_last", 128'(m_last), 128'(w.l));
        end
      end
      took = s_valid && s_ready;
      if (took) void'(byte_q.pop_front());
    end
    chk("rnd_timeout", 128'(byte_q.size() + exp_q.size()), 128'(0));

    m_ready = 1'b1;
    for (int i = 0; i < 3 * NB; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      if (frame_err) got_ferr++;
      if (m_valid) got_words++;
    end
    chk("rnd_word_count", 128'(got_words), 128'(words_planned));
    chk("rnd_ferr_count", 128'(got_ferr), 128'(exp_ferr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_unpack.md
DATA_UNPACK -- requirements
Module: data_unpack

Interface
REQ-001 Parameter BW, default 18, bit width of one IQ/bin lane.
REQ-002 Parameter N_PRL, default 4, number of parallel lanes per output word.
REQ-003 Parameter BW_IN, default 8, input byte width (ethernet receive side).
REQ-004 Derived constants: W = BW*N_PRL and NB = W/BW_IN; W not divisible by BW_IN SHALL be an elaboration error.
REQ-005 Port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 Port srest, input, 1, reset, synchronous and active-high.
REQ-007 Port s_data, input, BW_IN, received byte.
REQ-008 Port s_valid, input, 1, s_data/s_last valid.
REQ-009 Port s_ready, output, 1, block accepts a byte this cycle.
REQ-010 Port s_last, input, 1, byte is final byte of the frame.
REQ-011 Port m_x, output, [N_PRL-1:0][BW-1:0], reassembled lanes.
REQ-012 Port m_valid, output, 1, m_x/m_last hold a word.
REQ-013 Port m_ready, input, 1, downstream consumes the word.
REQ-014 Port m_last, output, 1, word closed its frame.
REQ-015 Port frame_err, output, 1, one-cycle pulse on short/partial frame.

Function
REQ-016 A byte SHALL be accepted when s_valid && s_ready; a word SHALL be consumed when m_valid && m_ready.
REQ-017 Byte order: k-th accepted byte of a word (k = 0..NB-1) SHALL occupy flat bits [BW_IN*k +: BW_IN]; lane i SHALL be flat[BW*i +: BW] (exact inverse of the transmit-side concat).
REQ-018 Byte counter cnt SHALL run 0..NB-1, increment per accepted byte, and wrap to 0 on the completing byte (cnt == NB-1).
REQ-019 FSM states: COLLECT (accumulating, cnt in use) and DROP (discarding rest of a bad frame); reset state is COLLECT with cnt = 0.
REQ-020 On the completing byte in COLLECT, the assembled word SHALL load into the output register with m_valid = 1 on the next cycle (latency 1 cycle from last byte accepted).
REQ-021 m_last SHALL equal s_last of the completing byte and be held with the word.
REQ-022 Output register holds m_x/m_valid/m_last stable until consumed; m_valid drops the cycle after consumption unless a new word loads in the same cycle.
REQ-023 s_ready SHALL be 0 only when cnt == NB-1, m_valid = 1 and m_ready = 0 (non-completing bytes are always accepted); s_ready is combinational from registered state and m_ready.
REQ-024 Simultaneous completing byte and consumption SHALL load the new word with no bubble, sustaining one word per NB cycles.
REQ-025 s_last on a byte with cnt != NB-1 SHALL discard the partial word, pulse frame_err for one cycle, reset cnt to 0, and stay in COLLECT.
REQ-026 A frame longer than expected is not detectable and SHALL simply yield further words; DROP is entered only via REQ-027.
REQ-027 If s_valid is seen while s_last of the previous accepted byte completed a word with m_last already pending and unconsumed, no special action; DROP SHALL be entered when an accepted byte has s_data X-free but cnt overflow is impossible -- DROP is reserved and exits to COLLECT on accepted s_last without emitting words.
REQ-028 frame_err SHALL never coincide with a word load.

Reset
REQ-029 While srest = 1: m_valid = 0, m_last = 0, m_x = 0, frame_err = 0, cnt = 0, state = COLLECT, s_ready = 0.
REQ-030 srest asserted mid-word or with a word pending SHALL discard both; the first byte accepted after srest deasserts is byte 0 of a new word.

Structure
REQ-031 Shared package SHALL hold the FSM state enum and a function computing NB from BW, N_PRL and BW_IN, reused by the transmit-side concat block.
REQ-032 One sub-module, byte_shift_acc (BW_IN-wide shift accumulator with load/clear), is natural; FSM, counter and output register live in data_unpack.

Verification
REQ-033 Defaults; bytes 0x01..0x09, s_last on 9th, m_ready = 1 -> m_x = {0x2420, 0x7060, 0x14100, 0x30201} (lane3..lane0), m_last = 1, 1 cycle after byte 9.
REQ-034 18 back-to-back 0xFF bytes, m_ready = 0 -> first word all lanes 0x3FFFF; s_ready = 0 on byte 18 until m_ready = 1, then second word loads with no bubble.
REQ-035 5 bytes then s_last on byte 6 -> frame_err pulses once, m_valid stays 0, next 9 bytes produce a correct word.
REQ-036 srest for 1 cycle after 4 bytes -> all outputs zero; next 9 bytes 0x10..0x18 form one word starting at 0x10 in byte 0.
REQ-037 Random s_valid/m_ready gaps, 1000 words vs. concat-block reference model -> bit-exact match, no lost or duplicated words.
